// File: rtl/bgpu_soc_pkg.sv
// Shared SoC-level types and default widths for the debug/memory OBI request path.
package bgpu_soc_pkg;

    localparam int unsigned DbgNumReq       = 2;
    localparam int unsigned DbgObiAddrWidth = 32;
    localparam int unsigned DbgObiDataWidth = 32;
    localparam int unsigned DbgObiMaxTrans  = 4;

    typedef logic [$clog2(DbgNumReq)-1:0] idx_t;

    // Index width that stays at least one bit wide for single-entry cases.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bgpu_obi_rr_arbiter_if.sv
// Bundle of the requester-side and manager-side OBI signals around the round-robin arbiter.
interface bgpu_obi_rr_arbiter_if
    import bgpu_soc_pkg::*;
#(
    parameter int unsigned NumReq    = DbgNumReq,
    parameter int unsigned AddrWidth = DbgObiAddrWidth,
    parameter int unsigned DataWidth = DbgObiDataWidth
);

    localparam int unsigned BeWidth = DataWidth / 8;

    logic [NumReq-1:0]           req;
    logic [NumReq-1:0]           we;
    logic [NumReq*AddrWidth-1:0] addr;
    logic [NumReq*DataWidth-1:0] wdata;
    logic [NumReq*BeWidth-1:0]   be;
    logic [NumReq-1:0]           gnt;
    logic [NumReq-1:0]           rvalid;
    logic [DataWidth-1:0]        rdata;
    logic                        err;

    logic                        m_req;
    logic                        m_we;
    logic [AddrWidth-1:0]        m_addr;
    logic [DataWidth-1:0]        m_wdata;
    logic [BeWidth-1:0]          m_be;
    logic                        m_gnt;
    logic                        m_rvalid;
    logic [DataWidth-1:0]        m_rdata;
    logic                        m_err;

    // Arbiter view: serves the requesters, drives the manager port.
    modport slave (
        input  req, we, addr, wdata, be, m_gnt, m_rvalid, m_rdata, m_err,
        output gnt, rvalid, rdata, err, m_req, m_we, m_addr, m_wdata, m_be
    );

    // Environment view: requesters plus the downstream manager.
    modport master (
        output req, we, addr, wdata, be, m_gnt, m_rvalid, m_rdata, m_err,
        input  gnt, rvalid, rdata, err, m_req, m_we, m_addr, m_wdata, m_be
    );

endinterface

// File: rtl/bgpu_obi_id_fifo.sv
// In-order FIFO of requester indices for granted-but-unanswered OBI transactions.
module bgpu_obi_id_fifo
    import bgpu_soc_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [Width-1:0]             data_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             data_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(Depth+1)-1:0]   fill_o
);

    localparam int unsigned PtrWidth = idx_width(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [Width-1:0]    mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] fill_q, fill_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push_i, pop_i})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (fill_q == '0);
    assign full_o  = (fill_q == CntWidth'(Depth));
    assign fill_o  = fill_q;

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o));

endmodule

// File: rtl/bgpu_obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NumReq requesters, with an
// in-order index FIFO that routes each response back to its issuer.
module bgpu_obi_rr_arbiter
    import bgpu_soc_pkg::*;
#(
    parameter int unsigned NumReq    = DbgNumReq,
    parameter int unsigned AddrWidth = DbgObiAddrWidth,
    parameter int unsigned DataWidth = DbgObiDataWidth,
    parameter int unsigned MaxTrans  = DbgObiMaxTrans
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    bgpu_obi_rr_arbiter_if.slave            bus,
    output logic [$clog2(MaxTrans+1)-1:0]   outstanding_o,
    output logic                            proto_err_o
);

    localparam int unsigned IdxWidth = idx_width(NumReq);
    localparam int unsigned BeWidth  = DataWidth / 8;

    typedef logic [IdxWidth-1:0] sel_t;

    sel_t rr_ptr_q, rr_ptr_d;
    sel_t locked_idx_q, locked_idx_d;
    logic lock_q, lock_d;
    logic proto_err_q, proto_err_d;

    sel_t rr_winner, winner, head;
    logic fifo_full, fifo_empty, push, pop, m_req;

    always_comb begin : rr_search
        logic        found;
        int unsigned cand;
        found     = 1'b0;
        cand      = 0;
        rr_winner = rr_ptr_q;
        for (int unsigned off = 0; off < NumReq; off++) begin
            cand = (32'(rr_ptr_q) + off) % NumReq;
            if (!found && bus.req[cand]) begin
                rr_winner = sel_t'(cand);
                found     = 1'b1;
            end
        end
    end

    // A stalled request keeps its slot until granted, regardless of the rotation.
    assign winner = lock_q ? locked_idx_q : rr_winner;
    assign m_req  = rst_ni & (|bus.req) & ~fifo_full;
    assign push   = m_req & bus.m_gnt;
    assign pop    = bus.m_rvalid & ~fifo_empty;

    always_comb begin
        bus.m_req   = m_req;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_be    = '0;
        bus.gnt     = '0;
        bus.rvalid  = '0;
        bus.rdata   = bus.m_rdata;
        bus.err     = bus.m_err;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (winner == sel_t'(i)) begin
                bus.m_we    = bus.we[i];
                bus.m_addr  = bus.addr[i*AddrWidth +: AddrWidth];
                bus.m_wdata = bus.wdata[i*DataWidth +: DataWidth];
                bus.m_be    = bus.be[i*BeWidth +: BeWidth];
                bus.gnt[i]  = push;
            end
            if (head == sel_t'(i)) begin
                bus.rvalid[i] = rst_ni & pop;
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        proto_err_d  = proto_err_q | (bus.m_rvalid & fifo_empty);
        if (push) begin
            rr_ptr_d = (winner == sel_t'(NumReq - 1)) ? '0 : winner + 1'b1;
            lock_d   = 1'b0;
        end else if (m_req) begin
            lock_d       = 1'b1;
            locked_idx_d = winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            locked_idx_q <= '0;
            lock_q       <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            locked_idx_q <= locked_idx_d;
            lock_q       <= lock_d;
            proto_err_q  <= proto_err_d;
        end
    end

    bgpu_obi_id_fifo #(
        .Depth (MaxTrans),
        .Width (IdxWidth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .fill_o  (outstanding_o)
    );

    assign proto_err_o = proto_err_q;

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.gnt));
    a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> $stable({bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be}));
    a_lock_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> bus.req[locked_idx_q]);

endmodule

// File: tb/tb_bgpu_obi_rr_arbiter.sv
// Directed bench for bgpu_obi_rr_arbiter with hand-computed expectations (NumReq=2, MaxTrans=4).
module tb_bgpu_obi_rr_arbiter;
    import bgpu_soc_pkg::*;

    localparam int unsigned NumReq    = 2;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned MaxTrans  = 4;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2004;
    localparam logic [31:0] W0 = 32'hAAAA_0000;
    localparam logic [31:0] W1 = 32'h5555_1111;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [2:0] outstanding;
    logic       proto_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk_i = ~clk_i;

    bgpu_obi_rr_arbiter_if #(
        .NumReq    (NumReq),
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) bus ();

    bgpu_obi_rr_arbiter #(
        .NumReq    (NumReq),
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .MaxTrans  (MaxTrans)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .bus           (bus),
        .outstanding_o (outstanding),
        .proto_err_o   (proto_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        bus.req      = '0;
        bus.we       = 2'b10;
        bus.addr     = {A1, A0};
        bus.wdata    = {W1, W0};
        bus.be       = 8'hF3;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        bus.m_err    = 1'b0;

        // Reset with requests pending: manager side must stay idle.
        #12;
        bus.req = 2'b11;
        #1;
        check_eq("rst_m_req", 64'(bus.m_req), 64'(0));
        check_eq("rst_gnt", 64'(bus.gnt), 64'(0));
        check_eq("rst_outstanding", 64'(outstanding), 64'(0));
        check_eq("rst_proto_err", 64'(proto_err), 64'(0));
        bus.req = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single read from requester 0.
        bus.req   = 2'b01;
        bus.m_gnt = 1'b1;
        #1;
        check_eq("t1_gnt", 64'(bus.gnt), 64'(2'b01));
        check_eq("t1_m_req", 64'(bus.m_req), 64'(1));
        check_eq("t1_m_addr", 64'(bus.m_addr), 64'(A0));
        check_eq("t1_out0", 64'(outstanding), 64'(0));
        tick();
        bus.req   = '0;
        bus.m_gnt = 1'b0;
        #1;
        check_eq("t1_out1", 64'(outstanding), 64'(1));
        tick();
        tick();
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'hDEAD_BEEF;
        #1;
        check_eq("t1_rvalid", 64'(bus.rvalid), 64'(2'b01));
        check_eq("t1_rdata", 64'(bus.rdata), 64'(32'hDEAD_BEEF));
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("t1_out_end", 64'(outstanding), 64'(0));

        // Both requesting, manager always grants; rotation currently points at requester 1.
        bus.req   = 2'b11;
        bus.m_gnt = 1'b1;
        #1;
        check_eq("t2_gnt_c1", 64'(bus.gnt), 64'(2'b10));
        tick();
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h1111_0001;
        #1;
        check_eq("t2_gnt_c2", 64'(bus.gnt), 64'(2'b01));
        check_eq("t2_rv_c2", 64'(bus.rvalid), 64'(2'b10));
        tick();
        #1;
        check_eq("t2_gnt_c3", 64'(bus.gnt), 64'(2'b10));
        check_eq("t2_rv_c3", 64'(bus.rvalid), 64'(2'b01));
        tick();
        #1;
        check_eq("t2_gnt_c4", 64'(bus.gnt), 64'(2'b01));
        check_eq("t2_rv_c4", 64'(bus.rvalid), 64'(2'b10));
        check_eq("t2_out_c4", 64'(outstanding), 64'(1));
        tick();
        bus.req   = '0;
        bus.m_gnt = 1'b0;
        #1;
        check_eq("t2_rv_c5", 64'(bus.rvalid), 64'(2'b01));
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("t2_out_end", 64'(outstanding), 64'(0));

        // Lock: rotate to requester 0 first, then stall requester 1 for three cycles.
        bus.req   = 2'b10;
        bus.m_gnt = 1'b1;
        #1;
        check_eq("t3_pre_gnt", 64'(bus.gnt), 64'(2'b10));
        tick();
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        #1;
        check_eq("t3_pre_rv", 64'(bus.rvalid), 64'(2'b10));
        check_eq("t3_s1_addr", 64'(bus.m_addr), 64'(A1));
        check_eq("t3_s1_gnt", 64'(bus.gnt), 64'(0));
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("t3_s2_addr", 64'(bus.m_addr), 64'(A1));
        tick();
        bus.req = 2'b11;
        #1;
        check_eq("t3_s3_addr", 64'(bus.m_addr), 64'(A1));
        check_eq("t3_s3_we", 64'(bus.m_we), 64'(1));
        check_eq("t3_s3_wdata", 64'(bus.m_wdata), 64'(W1));
        tick();
        bus.m_gnt = 1'b1;
        #1;
        check_eq("t3_gnt1", 64'(bus.gnt), 64'(2'b10));
        check_eq("t3_gnt1_addr", 64'(bus.m_addr), 64'(A1));
        tick();
        #1;
        check_eq("t3_gnt0", 64'(bus.gnt), 64'(2'b01));
        check_eq("t3_gnt0_addr", 64'(bus.m_addr), 64'(A0));
        check_eq("t3_gnt0_be", 64'(bus.m_be), 64'(4'h3));
        tick();
        bus.req      = '0;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        #1;
        check_eq("t3_out2", 64'(outstanding), 64'(2));
        check_eq("t3_rv_a", 64'(bus.rvalid), 64'(2'b10));
        tick();
        #1;
        check_eq("t3_rv_b", 64'(bus.rvalid), 64'(2'b01));
        tick();
        bus.m_rvalid = 1'b0;

        // Fill the ID FIFO with four requester-0 transactions.
        bus.req   = 2'b01;
        bus.m_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("t4_gnt_%0d", k), 64'(bus.gnt), 64'(2'b01));
            check_eq($sformatf("t4_out_%0d", k), 64'(outstanding), 64'(k));
            tick();
        end
        #1;
        check_eq("t4_full_out", 64'(outstanding), 64'(4));
        check_eq("t4_full_m_req", 64'(bus.m_req), 64'(0));
        check_eq("t4_full_gnt", 64'(bus.gnt), 64'(0));
        bus.m_rvalid = 1'b1;
        #1;
        check_eq("t4_full_rv", 64'(bus.rvalid), 64'(2'b01));
        check_eq("t4_full_rv_m_req", 64'(bus.m_req), 64'(0));
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("t4_reopen_out", 64'(outstanding), 64'(3));
        check_eq("t4_reopen_m_req", 64'(bus.m_req), 64'(1));
        check_eq("t4_reopen_gnt", 64'(bus.gnt), 64'(2'b01));
        tick();
        bus.req      = '0;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("t4_drain_rv_%0d", k), 64'(bus.rvalid), 64'(2'b01));
            tick();
        end
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("t4_drain_out", 64'(outstanding), 64'(0));

        // Stray response with nothing outstanding.
        bus.m_rvalid = 1'b1;
        #1;
        check_eq("t5_rv", 64'(bus.rvalid), 64'(0));
        check_eq("t5_perr_pre", 64'(proto_err), 64'(0));
        tick();
        bus.m_rvalid = 1'b0;
        #1;
        check_eq("t5_perr_set", 64'(proto_err), 64'(1));
        check_eq("t5_out", 64'(outstanding), 64'(0));
        tick();
        tick();
        check_eq("t5_perr_sticky", 64'(proto_err), 64'(1));

        // Reset with two outstanding and requester 1 locked.
        bus.req   = 2'b01;
        bus.m_gnt = 1'b1;
        tick();
        tick();
        bus.req   = 2'b11;
        bus.m_gnt = 1'b0;
        tick();
        #1;
        check_eq("t6_out2", 64'(outstanding), 64'(2));
        check_eq("t6_locked_addr", 64'(bus.m_addr), 64'(A1));
        bus.m_rvalid = 1'b1;
        rst_ni       = 1'b0;
        #1;
        check_eq("t6_rst_m_req", 64'(bus.m_req), 64'(0));
        check_eq("t6_rst_gnt", 64'(bus.gnt), 64'(0));
        check_eq("t6_rst_rv", 64'(bus.rvalid), 64'(0));
        check_eq("t6_rst_out", 64'(outstanding), 64'(0));
        check_eq("t6_rst_perr", 64'(proto_err), 64'(0));
        tick();
        rst_ni       = 1'b1;
        bus.m_rvalid = 1'b0;
        bus.m_gnt    = 1'b1;
        #1;
        check_eq("t6_post_gnt", 64'(bus.gnt), 64'(2'b01));
        check_eq("t6_post_addr", 64'(bus.m_addr), 64'(A0));
        tick();
        bus.req   = '0;
        bus.m_gnt = 1'b0;
        #1;
        check_eq("t6_post_out", 64'(outstanding), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
